// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK sequence driver.
// Optional readback compare is enabled by defining JK_SEQ_READBACK_EN.
package jk_seq_pkg;

    localparam int unsigned JK_WIDTH_DEFAULT = 4;
    localparam int unsigned JK_DEPTH_DEFAULT = 4;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } jk_seq_state_t;

    // J/K drive pair for one flop.
    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    // JK excitation for one bit; don't-cares resolved to 0 so the toggle row is never used.
    function automatic jk_pair_t jk_excite(input logic tgt, input logic q);
        jk_pair_t pair;
        pair.j = tgt & ~q;
        pair.k = ~tgt & q;
        return pair;
    endfunction

endpackage : jk_seq_pkg

// File: rtl/jk_seq_fifo.sv
// Small synchronous FIFO buffering target words for the JK sequence driver.
// Pointers wrap modulo DEPTH (power of 2); occupancy count is $clog2(DEPTH)+1 bits.
module jk_seq_fifo
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = JK_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = JK_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // Writes are refused when full, reads when empty.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : jk_seq_fifo

// File: rtl/jk_seq_driver.sv
// Drives a bank of WIDTH external JK flops through a buffered sequence of target states.
// Each target runs IDLE (pop, compute J/K) -> DRIVE (J/K applied) -> CHECK (done pulse).
// Define JK_SEQ_READBACK_EN to build the sticky q_fb-vs-target readback check on err.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = JK_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = JK_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    jk_seq_state_t    state;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;

    // Accept while not full; the head is consumed only from IDLE.
    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    jk_seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_target),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Per-bit excitation of the head target against the live flop state.
    always_comb begin
        jk_pair_t pair;
        pair  = '0;
        j_nxt = '0;
        k_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pair     = jk_excite(head[i], q_fb[i]);
            j_nxt[i] = pair.j;
            k_nxt[i] = pair.k;
        end
    end

    // Sequencer with registered J/K and done; J/K are nonzero only while in DRIVE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
        end else begin
            j    <= '0;
            k    <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= DRIVE;
                        j     <= j_nxt;
                        k     <= k_nxt;
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                    done  <= 1'b1;
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef JK_SEQ_READBACK_EN
    logic [WIDTH-1:0] tgt_r;

    // Remember the target being applied so CHECK can compare the flops against it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_r <= '0;
        end else if (fifo_pop) begin
            tgt_r <= head;
        end
    end

    // Sticky readback mismatch; sequencing carries on regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state == CHECK) && (q_fb != tgt_r)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule : jk_seq_driver
